// File: rtl/chronospatial_run_ctrl.sv
// Run controller for the chronospatial 3-bit core: host command decode,
// program/register-A load strobes, run sequencing and output digit FIFO.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   host_valid/host_data/host_ready  byte command channel, [7:5] op, [4:0] arg
//   prog_wr_en/addr/data             registered program write strobe
//   rega_wr_en/rega_wr_data          registered register-A nibble strobe
//   core_run                         core reset release
//   core_halt/core_out_valid/core_reg_out  core status and output digits
//   out_valid/out_data/out_pop       first-word-fall-through FIFO head
//   done/timed_out/aborted/overflow  run status flags
module chronospatial_run_ctrl #(
  parameter int PROG_AW    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_CYC    = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_valid,
  input  logic [7:0]         host_data,
  output logic               host_ready,
  output logic               prog_wr_en,
  output logic [PROG_AW-1:0] prog_wr_addr,
  output logic [2:0]         prog_wr_data,
  output logic               rega_wr_en,
  output logic [3:0]         rega_wr_data,
  output logic               core_run,
  input  logic               core_halt,
  input  logic               core_out_valid,
  input  logic [2:0]         core_reg_out,
  output logic               out_valid,
  output logic [2:0]         out_data,
  input  logic               out_pop,
  output logic               done,
  output logic               timed_out,
  output logic               aborted,
  output logic               overflow
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(MAX_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [PROG_AW-1:0] prog_ptr;
  logic [CW-1:0]      cyc_cnt;

  logic [2:0] mem [FIFO_DEPTH];
  logic [FAW-1:0] rd_ptr;
  logic [FAW-1:0] wr_ptr;
  logic [FAW:0]   count;

  logic       accept;
  logic [2:0] op;
  logic [4:0] arg;
  logic       cfg;
  logic       in_run;
  logic       cmd_prog;
  logic       cmd_rega;
  logic       cmd_clr;
  logic       cmd_start;
  logic       cmd_abort;
  logic       hit_to;
  logic       push;
  logic       pop;
  logic       full;
  logic       wr_ok;
  logic       unused_arg;

  assign accept     = host_valid & host_ready;
  assign op         = host_data[7:5];
  assign arg        = host_data[4:0];
  assign unused_arg = arg[4];
  assign in_run     = (state == S_RUN);
  assign cfg        = ~in_run;

  assign cmd_prog  = accept & cfg & (op == 3'b000);
  assign cmd_rega  = accept & cfg & (op == 3'b001);
  assign cmd_clr   = accept & cfg & (op == 3'b010);
  assign cmd_start = accept & cfg & (op == 3'b011);
  assign cmd_abort = accept & in_run & (op == 3'b100);

  assign hit_to = in_run & (cyc_cnt == CW'(MAX_CYC - 1));

  assign push  = in_run & core_out_valid;
  assign pop   = out_pop & out_valid;
  assign full  = (count == (FAW+1)'(FIFO_DEPTH));
  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign wr_ok = push & (~full | pop);

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      host_ready   <= 1'b1;
      prog_wr_en   <= 1'b0;
      prog_wr_addr <= '0;
      prog_wr_data <= '0;
      rega_wr_en   <= 1'b0;
      rega_wr_data <= '0;
      prog_ptr     <= '0;
      cyc_cnt      <= '0;
      core_run     <= 1'b0;
      done         <= 1'b0;
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      host_ready <= ~accept;
      prog_wr_en <= cmd_prog;
      rega_wr_en <= cmd_rega;
      if (cmd_prog) begin
        prog_wr_addr <= prog_ptr;
        prog_wr_data <= arg[2:0];
        prog_ptr     <= prog_ptr + 1'b1;
      end
      if (cmd_clr)
        prog_ptr <= '0;
      if (cmd_rega)
        rega_wr_data <= arg[3:0];
      if (push & full & ~pop)
        overflow <= 1'b1;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (cmd_start) begin
            state     <= S_RUN;
            core_run  <= 1'b1;
            cyc_cnt   <= '0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            aborted   <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        S_RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          // halt beats timeout beats abort
          if (core_halt) begin
            state    <= S_DONE;
            core_run <= 1'b0;
            done     <= 1'b1;
          end else if (hit_to) begin
            state     <= S_DONE;
            core_run  <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else if (cmd_abort) begin
            state    <= S_DONE;
            core_run <= 1'b0;
            done     <= 1'b1;
            aborted  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          core_run <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (cmd_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= core_reg_out;
  end

endmodule

// File: tb/tb_chronospatial_run_ctrl.sv
// Directed self-checking bench for chronospatial_run_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_chronospatial_run_ctrl;

  localparam int PAW = 4;
  localparam int FD  = 8;
  localparam int MC  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           host_valid;
  logic [7:0]     host_data;
  logic           host_ready;
  logic           prog_wr_en;
  logic [PAW-1:0] prog_wr_addr;
  logic [2:0]     prog_wr_data;
  logic           rega_wr_en;
  logic [3:0]     rega_wr_data;
  logic           core_run;
  logic           core_halt;
  logic           core_out_valid;
  logic [2:0]     core_reg_out;
  logic           out_valid;
  logic [2:0]     out_data;
  logic           out_pop;
  logic           done;
  logic           timed_out;
  logic           aborted;
  logic           overflow;

  int n_run  = 0;
  int n_fail = 0;

  chronospatial_run_ctrl #(
    .PROG_AW   (PAW),
    .FIFO_DEPTH(FD),
    .MAX_CYC   (MC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .prog_wr_en    (prog_wr_en),
    .prog_wr_addr  (prog_wr_addr),
    .prog_wr_data  (prog_wr_data),
    .rega_wr_en    (rega_wr_en),
    .rega_wr_data  (rega_wr_data),
    .core_run      (core_run),
    .core_halt     (core_halt),
    .core_out_valid(core_out_valid),
    .core_reg_out  (core_reg_out),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_pop       (out_pop),
    .done          (done),
    .timed_out     (timed_out),
    .aborted       (aborted),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] arg);
    chk("ready_before", host_ready, 1);
    host_valid = 1'b1;
    host_data  = {op, arg};
    tick();
    host_valid = 1'b0;
    host_data  = '0;
  endtask

  task automatic drain(input logic [2:0] exp);
    chk("fifo_valid", out_valid, 1);
    chk("fifo_data", out_data, exp);
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pl [8];
    logic [2:0] ov [8];
    int run_len;
    pl = '{3'd2, 3'd4, 3'd1, 3'd1, 3'd7, 3'd5, 3'd1, 3'd5};
    ov = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd6};
    rst_n          = 1'b0;
    host_valid     = 1'b0;
    host_data      = '0;
    core_halt      = 1'b0;
    core_out_valid = 1'b0;
    core_reg_out   = '0;
    out_pop        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", host_ready, 1);
    chk("rst_run", core_run, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_prog_en", prog_wr_en, 0);
    rst_n = 1'b1;
    tick();

    // program load
    for (int i = 0; i < 8; i++) begin
      send(3'b000, {2'b00, pl[i]});
      chk("prog_en", prog_wr_en, 1);
      chk("prog_addr", prog_wr_addr, i);
      chk("prog_data", prog_wr_data, pl[i]);
      chk("ready_low", host_ready, 0);
      tick();
      chk("prog_en_off", prog_wr_en, 0);
      chk("ready_back", host_ready, 1);
    end
    send(3'b010, 5'd0);
    chk("clr_no_wr", prog_wr_en, 0);
    tick();
    send(3'b000, 5'd3);
    chk("clr_addr", prog_wr_addr, 0);
    tick();

    // wrap after 16 writes
    send(3'b010, 5'd0);
    tick();
    for (int i = 0; i < 17; i++) begin
      send(3'b000, 5'd1);
      if (i == 15) chk("wrap_last", prog_wr_addr, 15);
      if (i == 16) chk("wrap_addr", prog_wr_addr, 0);
      tick();
    end

    // register A nibble
    send(3'b001, 5'h1a);
    chk("rega_en", rega_wr_en, 1);
    chk("rega_data", rega_wr_data, 4'ha);
    chk("rega_no_prog", prog_wr_en, 0);
    tick();
    chk("rega_off", rega_wr_en, 0);

    // illegal ABORT and reserved opcode in IDLE
    send(3'b100, 5'd0);
    chk("idle_abort_run", core_run, 0);
    chk("idle_abort_aborted", aborted, 0);
    chk("idle_abort_ready", host_ready, 0);
    tick();
    send(3'b111, 5'h1f);
    chk("nop_prog", prog_wr_en, 0);
    chk("nop_rega", rega_wr_en, 0);
    tick();

    // normal run
    send(3'b011, 5'd0);
    chk("run_start", core_run, 1);
    core_out_valid = 1'b1;
    core_reg_out   = 3'd3;
    tick();
    core_reg_out = 3'd5;
    tick();
    core_reg_out = 3'd1;
    tick();
    core_out_valid = 1'b0;
    chk("run_still", core_run, 1);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("halt_run", core_run, 0);
    chk("halt_done", done, 1);
    chk("halt_to", timed_out, 0);
    chk("halt_ab", aborted, 0);
    chk("halt_ov", overflow, 0);
    drain(3'd3);
    drain(3'd5);
    drain(3'd1);
    chk("drain_empty", out_valid, 0);

    // timeout
    send(3'b011, 5'd0);
    chk("to_done_clr", done, 0);
    run_len = 0;
    while (core_run && run_len < 100) begin
      run_len++;
      tick();
    end
    chk("to_len", run_len, MC);
    chk("to_done", done, 1);
    chk("to_flag", timed_out, 1);
    chk("to_ab", aborted, 0);

    // overflow
    tick();
    send(3'b011, 5'd0);
    chk("ov_to_clr", timed_out, 0);
    for (int i = 0; i < 9; i++) begin
      core_out_valid = 1'b1;
      core_reg_out   = 3'((i + 1) % 8);
      if (i == 8) core_reg_out = 3'd5;
      tick();
    end
    chk("ov_flag", overflow, 1);
    core_reg_out = 3'd6;
    out_pop      = 1'b1;
    tick();
    out_pop        = 1'b0;
    core_out_valid = 1'b0;
    core_halt      = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("ov_done", done, 1);
    chk("ov_sticky", overflow, 1);
    for (int i = 0; i < 7; i++)
      drain(ov[i]);
    chk("ov_last_valid", out_valid, 1);
    chk("ov_last_data", out_data, ov[7]);
    send(3'b011, 5'd0);
    chk("start_fifo_clr", out_valid, 0);
    chk("start_ov_clr", overflow, 0);
    chk("start_done_clr", done, 0);
    chk("start_run", core_run, 1);

    // ABORT alone
    tick();
    send(3'b100, 5'd0);
    chk("ab_run", core_run, 0);
    chk("ab_done", done, 1);
    chk("ab_flag", aborted, 1);

    // ABORT and halt together: halt wins
    tick();
    send(3'b011, 5'd0);
    chk("ab2_clr", aborted, 0);
    tick();
    core_halt = 1'b1;
    send(3'b100, 5'd0);
    core_halt = 1'b0;
    chk("hab_run", core_run, 0);
    chk("hab_done", done, 1);
    chk("hab_ab", aborted, 0);

    // reset mid-run
    tick();
    send(3'b011, 5'd0);
    core_out_valid = 1'b1;
    core_reg_out   = 3'd4;
    tick();
    core_out_valid = 1'b0;
    chk("mr_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_run", core_run, 0);
    chk("mr_fifo", out_valid, 0);
    chk("mr_ready", host_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_idle", core_run, 0);
    send(3'b000, 5'd7);
    chk("mr_prog_en", prog_wr_en, 1);
    chk("mr_prog_addr", prog_wr_addr, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
